pipelined_csel_adder: RTL and testbench

- Parameterised, pipelined carry-select adder/subtractor. Successor to the 4-bit combinational carry-select adder.
- Operands are split into BLK-bit blocks. Each block precomputes sums for carry-in 0 and carry-in 1, and one pipeline stage per block selects the result using the carry from the previous stage.
- Valid/ready handshake on input and output. Full throughput of one operation per cycle, with backpressure.
- Sits between operand registers and the result consumer in the datapath.

---
 rtl/pipelined_csel_adder_pkg.sv | 21 ++
 rtl/pipelined_csel_adder_if.sv | 36 +++
 rtl/csel_block.sv | 42 ++++
 rtl/pipelined_csel_adder.sv | 115 +++++++++++
 tb/tb_pipelined_csel_adder.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_csel_adder_pkg.sv
// ---------------------------------------------------------------------------
// pipelined_csel_adder_pkg
// Shared defaults for the pipelined carry-select adder: default operand width,
// default block width, and the block-count macro used to size the pipeline.
// No ports.
// ---------------------------------------------------------------------------
`ifndef CSEL_NBLK
`define CSEL_NBLK(w, b) ((w) / (b))
`endif

package pipelined_csel_adder_pkg;

    localparam int CSEL_DEF_WIDTH = 16;
    localparam int CSEL_DEF_BLK   = 4;

    // Number of carry-select blocks (and pipeline stages) for a width/block pair.
    function automatic int csel_nblk(input int w, input int b);
        return w / b;
    endfunction

endpackage

// File: rtl/pipelined_csel_adder_if.sv
// ---------------------------------------------------------------------------
// pipelined_csel_adder_if
// Operand/result bus of the pipelined carry-select adder.
//   in_valid/in_ready : operand handshake (a, b, cin, sub)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
// Modports: master = operand producer / result consumer, slave = adder.
// ---------------------------------------------------------------------------
interface pipelined_csel_adder_if
    import pipelined_csel_adder_pkg::*;
#(
    parameter int WIDTH = CSEL_DEF_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/csel_block.sv
// ---------------------------------------------------------------------------
// csel_block
// One carry-select block: two BLK-bit ripple adders with fixed carry-in 0
// and 1. No muxing; the caller selects with the real carry.
//   i_a, i_b     : block operands
//   o_s0, o_c0   : sum / carry-out assuming carry-in 0
//   o_s1, o_c1   : sum / carry-out assuming carry-in 1
// ---------------------------------------------------------------------------
module csel_block
    import pipelined_csel_adder_pkg::*;
#(
    parameter int BLK = CSEL_DEF_BLK
) (
    input  logic [BLK-1:0] i_a,
    input  logic [BLK-1:0] i_b,
    output logic [BLK-1:0] o_s0,
    output logic           o_c0,
    output logic [BLK-1:0] o_s1,
    output logic           o_c1
);

    logic [BLK:0] w_r0;
    logic [BLK:0] w_r1;

    always_comb begin
        w_r0    = '0;
        w_r1    = '0;
        o_s0    = '0;
        o_s1    = '0;
        w_r1[0] = 1'b1;
        for (int i = 0; i < BLK; i++) begin
            o_s0[i]   = i_a[i] ^ i_b[i] ^ w_r0[i];
            w_r0[i+1] = (i_a[i] & i_b[i]) | (w_r0[i] & (i_a[i] ^ i_b[i]));
            o_s1[i]   = i_a[i] ^ i_b[i] ^ w_r1[i];
            w_r1[i+1] = (i_a[i] & i_b[i]) | (w_r1[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_c0 = w_r0[BLK];
    assign o_c1 = w_r1[BLK];

endmodule

// File: rtl/pipelined_csel_adder.sv
// ---------------------------------------------------------------------------
// pipelined_csel_adder
// Pipelined carry-select adder/subtractor with valid/ready on both sides.
// Stage k resolves block k using the carry registered by stage k-1; the
// output register is stage NBLK-1. The whole pipe advances when the output
// is empty or being taken; there is no bubble compression.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of pipelined_csel_adder_if (operands in, result out)
// ---------------------------------------------------------------------------
module pipelined_csel_adder
    import pipelined_csel_adder_pkg::*;
#(
    parameter int WIDTH = CSEL_DEF_WIDTH,
    parameter int BLK   = CSEL_DEF_BLK
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipelined_csel_adder_if.slave bus
);

    localparam int NBLK = `CSEL_NBLK(WIDTH, BLK);
    localparam logic [WIDTH-1:0] BMASK = WIDTH'({BLK{1'b1}});

    if ((BLK < 1) || (WIDTH < BLK) || ((WIDTH % BLK) != 0)) begin : g_bad_params
        $error("pipelined_csel_adder: WIDTH (%0d) must be a positive multiple of BLK (%0d)",
               WIDTH, BLK);
    end

    // Stage registers: pass-through operands, partial sum, carry into next block, valid.
    logic [WIDTH-1:0] r_a [NBLK];
    logic [WIDTH-1:0] r_b [NBLK];
    logic [WIDTH-1:0] r_s [NBLK];
    logic             r_c [NBLK];
    logic             r_v [NBLK];

    // Inputs seen by each stage and the block result it selects.
    logic [WIDTH-1:0] w_stg_a [NBLK];
    logic [WIDTH-1:0] w_stg_b [NBLK];
    logic [WIDTH-1:0] w_stg_s [NBLK];
    logic             w_stg_c [NBLK];
    logic             w_stg_v [NBLK];
    logic [BLK-1:0]   w_sel   [NBLK];
    logic             w_cnext [NBLK];

    logic             w_adv;

    assign w_adv = ~r_v[NBLK-1] | bus.out_ready;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        logic [BLK-1:0] w_s0;
        logic [BLK-1:0] w_s1;
        logic           w_c0;
        logic           w_c1;

        if (k == 0) begin : g_first
            // Operand conditioning: subtraction is a + ~b + 1.
            assign w_stg_a[k] = bus.a;
            assign w_stg_b[k] = bus.sub ? ~bus.b : bus.b;
            assign w_stg_s[k] = '0;
            assign w_stg_c[k] = bus.sub ? 1'b1 : bus.cin;
            assign w_stg_v[k] = bus.in_valid;
        end else begin : g_next
            assign w_stg_a[k] = r_a[k-1];
            assign w_stg_b[k] = r_b[k-1];
            assign w_stg_s[k] = r_s[k-1];
            assign w_stg_c[k] = r_c[k-1];
            assign w_stg_v[k] = r_v[k-1];
        end

        csel_block #(
            .BLK (BLK)
        ) u_blk (
            .i_a  (w_stg_a[k][k*BLK +: BLK]),
            .i_b  (w_stg_b[k][k*BLK +: BLK]),
            .o_s0 (w_s0),
            .o_c0 (w_c0),
            .o_s1 (w_s1),
            .o_c1 (w_c1)
        );

        assign w_sel[k]   = w_stg_c[k] ? w_s1 : w_s0;
        assign w_cnext[k] = w_stg_c[k] ? w_c1 : w_c0;
    end

    // Stage 0 .. NBLK-1 boundary: every stage shifts together or holds together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NBLK; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
                r_v[k] <= 1'b0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < NBLK; k++) begin
                r_a[k] <= w_stg_a[k];
                r_b[k] <= w_stg_b[k];
                r_s[k] <= (w_stg_s[k] & ~(BMASK << (k*BLK))) | (WIDTH'(w_sel[k]) << (k*BLK));
                r_c[k] <= w_cnext[k];
                r_v[k] <= w_stg_v[k];
            end
        end
    end

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_v[NBLK-1];
    assign bus.sum       = r_s[NBLK-1];
    assign bus.cout      = r_c[NBLK-1];
    // Same-sign operands producing a different-sign result; b is already inverted for sub.
    assign bus.ovf       = (r_a[NBLK-1][WIDTH-1] == r_b[NBLK-1][WIDTH-1]) &
                           (r_s[NBLK-1][WIDTH-1] != r_a[NBLK-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_csel_adder.sv
module tb_pipelined_csel_adder;

    localparam int W  = 16;
    localparam int NB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipelined_csel_adder_if #(.WIDTH(W)) bus ();

    pipelined_csel_adder #(
        .WIDTH (W),
        .BLK   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t   sb[$];
    int     out_cyc_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    logic   prev_stall = 1'b0;
    logic [W-1:0] prev_sum = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: a + (sub ? ~b : b) + (sub ? 1 : cin), flags from operand/result MSBs.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic ci, input logic s);
        logic [W-1:0] be;
        logic [W:0]   r;
        logic         o;
        be = s ? ~b : b;
        r  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (s ? 1'b1 : ci)};
        o  = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
        return {o, r};
    endfunction

    // Output monitor: scoreboard pop, latency, and hold-while-stalled checks.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_sum", 32'(bus.sum), 32'(prev_sum));
            end
            if (bus.out_valid && !bus.out_ready)
                chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("out_with_empty_sb", 32'(sb.size()), 32'd1);
                end else begin
                    chk("sum", 32'(bus.sum), 32'(sb[0].sum));
                    chk("cout", 32'(bus.cout), 32'(sb[0].cout));
                    chk("ovf", 32'(bus.ovf), 32'(sb[0].ovf));
                    if (sb[0].lat) chk("latency", 32'(cyc), 32'(sb[0].acc + NB - 1));
                    sb.delete(0);
                    out_cyc_q.push_back(cyc);
                end
            end
            prev_stall <= bus.out_valid && !bus.out_ready;
            prev_sum   <= bus.sum;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic s, input logic [W-1:0] es, input logic ec,
                        input logic eo, input bit lat);
        bit accepted;
        accepted     = 1'b0;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = ci;
        bus.sub      = s;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 64 && !accepted; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back('{es, ec, eo, cyc + 1, lat});
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        chk("send_accept", 32'(accepted), 32'd1);
    endtask

    task automatic send_m(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic s, input bit lat);
        logic [W+1:0] r;
        r = ref_add(a, b, ci, s);
        send(a, b, ci, s, r[W-1:0], r[W], r[W+1], lat);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        for (int t = 0; t < 100 && sb.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Simple add with explicit latency probe
        send(16'h0003, 16'h000A, 1'b0, 1'b0, 16'h000D, 1'b0, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        repeat (NB - 1) begin
            @(negedge clk);
            chk("lat_not_yet", 32'(bus.out_valid), 32'd0);
        end
        @(negedge clk);
        chk("lat_arrive", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;

        // Carry ripple, subtraction, overflow corners
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        send(16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        send(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1);
        drain();

        // Back-to-back stream at full throughput
        out_cyc_q.delete();
        for (int i = 0; i < 8; i++)
            send(W'(i), W'(16'h0100 * i), 1'b0, 1'b0, W'(16'h0101 * i), 1'b0, 1'b0, 1'b1);
        drain();
        chk("stream_count", 32'(out_cyc_q.size()), 32'd8);
        if (out_cyc_q.size() == 8)
            chk("stream_consecutive", 32'(out_cyc_q[7] - out_cyc_q[0]), 32'd7);

        // Stream with out_ready dropped for 3 cycles mid-way
        out_cyc_q.delete();
        fork
            begin
                repeat (5) @(posedge clk);
                #2 bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #2 bus.out_ready = 1'b1;
            end
        join_none
        for (int i = 8; i < 16; i++)
            send(W'(i), W'(16'h0100 * i), 1'b0, 1'b0, W'(16'h0101 * i), 1'b0, 1'b0, 1'b0);
        drain();
        chk("stall_count", 32'(out_cyc_q.size()), 32'd8);

        // Asynchronous reset with operations in flight
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++)
            send(W'(16'h1111 * i), W'(16'h0001), 1'b0, 1'b0, W'(16'h1111 * i + 1), 1'b0, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        sb.delete();
        bus.in_valid = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_sum", 32'(bus.sum), 32'd0);
        chk("arst_cout", 32'(bus.cout), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("no_stale_after_rst", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
        drain();

        // Bubbles: alternating in_valid
        out_cyc_q.delete();
        for (int i = 0; i < 4; i++) begin
            send_m(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            idle(1);
        end
        drain();
        chk("bubble_count", 32'(out_cyc_q.size()), 32'd4);
        for (int i = 1; i < out_cyc_q.size(); i++)
            chk("bubble_spacing", 32'(out_cyc_q[i] - out_cyc_q[i-1]), 32'd2);

        // Random operands with random backpressure and gaps
        fork
            begin
                repeat (40) begin
                    @(posedge clk);
                    #2 bus.out_ready = 1'($urandom);
                end
                bus.out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 16; i++) begin
            send_m(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            if ($urandom_range(1, 0) == 1) idle(1);
        end
        for (int t = 0; t < 60 && !bus.out_ready; t++) begin
            @(posedge clk);
            #1;
        end
        repeat (45) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();

        chk("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
